grf_multiport: RTL

Parametrised general-purpose register file for the dual-issue pipeline. It provides NR combinational read ports and two synchronous write ports, with same-cycle write-to-read bypass and a hardwired-zero register 0. A per-register busy scoreboard records in-flight destinations, so the hazard unit can stall readers of pending registers without keeping its own copy of destination state.

---
 rtl/grf_multiport.sv | 86 ++++++++
 1 files changed

// File: rtl/grf_multiport.sv
// grf_multiport: multiport register file with two write ports, same-cycle bypass, hardwired-zero r0 and busy scoreboard
// Ports: clk/reset (sync, active-high); ra/rd/rd_busy = NR packed combinational read ports;
// we0/wa0/wd0 and we1/wa1/wd1 = write ports (port 1 wins on clash); bs/bsa = busy-set strobe;
// busy_cnt = registered count of busy registers; err_dbl_set = sticky double-set flag.
module grf_multiport #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rd_busy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic             bs,
  input  logic [AW-1:0]    bsa,
  output logic [AW:0]      busy_cnt,
  output logic             err_dbl_set
);
  localparam int DEPTH = 2**AW;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      r_cnt;
  logic             r_err;
  logic             w_z;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_set;
  logic             w_inc;
  logic             w_dec0;
  logic             w_dec1;
  logic             w_err;
  assign w_z    = ZERO_REG != 0;
  assign w_wr1  = we1 && !(w_z && wa1 == '0);
  assign w_wr0  = we0 && !(we1 && wa1 == wa0) && !(w_z && wa0 == '0);
  assign w_set  = bs && !(w_z && bsa == '0);
  assign w_inc  = w_set && !r_busy[bsa];
  // a same-address write pair clears its busy bit only once, so port 1 yields to port 0 here
  assign w_dec0 = we0 && r_busy[wa0] && !(w_set && bsa == wa0);
  assign w_dec1 = we1 && r_busy[wa1] && !(w_set && bsa == wa1) && !(we0 && wa0 == wa1);
  assign w_err  = w_set && r_busy[bsa] && !((we0 && wa0 == bsa) || (we1 && wa1 == bsa));
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      w_busy_nxt[r] = (w_set && bsa == AW'(r)) ? 1'b1 :
                      ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) ? 1'b0 : r_busy[r];
    end
    if (w_z) w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr1) r_mem[wa1] <= wd1;
      if (w_wr0) r_mem[wa0] <= wd0;
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec0) - (AW+1)'(w_dec1);
      if (w_err) r_err <= 1'b1;
    end
  end
  assign busy_cnt    = r_cnt;
  assign err_dbl_set = r_err;
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit0;
    logic          w_hit1;
    logic          w_zr;
    assign w_ra   = ra[i*AW +: AW];
    assign w_hit1 = !reset && we1 && wa1 == w_ra;
    assign w_hit0 = !reset && we0 && wa0 == w_ra;
    assign w_zr   = w_z && w_ra == '0;
    assign rd[i*DW +: DW] = w_zr ? '0 : w_hit1 ? wd1 : w_hit0 ? wd0 : r_mem[w_ra];
    assign rd_busy[i] = !reset && !w_zr && r_busy[w_ra] && !w_hit0 && !w_hit1;
  end
endmodule
